i2c_write_master: RTL and testbench
===================================

// Module: i2c_write_master
// PURPOSE
//  Parametrised I2C write-only master for codec/peripheral register setup.
//  Sends START, address byte {dev_addr,0}, then 0..MAX_BYTES data bytes, then STOP.
//  Checks every ACK, aborts on NACK, divides Clk down to SCL and drives SDA open-drain.
//  Sits between the config sequencer (start/done handshake) and the board I2C pins.
// PARAMETERS
//  CLK_DIV    4  Clk cycles per SCL quarter-period (tq); legal >=1; SCL period = 4*CLK_DIV.
//  MAX_BYTES  2  Max data bytes per transaction after the address byte; legal 1..16.
//  NB_W       $clog2(MAX_BYTES+1)  Width of nbytes (derived; do not override).
// PORTS
//  Clk        in   1              System clock; all logic on posedge.
//  Reset      in   1              Synchronous, active-low reset.
//  start      in   1              Request; accepted only in IDLE.
//  dev_addr   in   7              7-bit slave address; latched on accept.
//  nbytes     in   NB_W           Data byte count; latched on accept; >MAX_BYTES clamps to MAX_BYTES.
//  wr_data    in   8*MAX_BYTES    Data bytes; byte0 = [8*MAX_BYTES-1 -: 8], sent first, MSB first.
//  busy       out  1              High in every state except IDLE.
//  done       out  1              One-cycle pulse at transaction end (success or NACK).
//  nack       out  1              Set if any ACK slot read 1; valid with done; cleared on next accept.
//  nack_idx   out  NB_W           Byte index that NACKed (0 = address byte); valid when nack=1.
//  scl_o      out  1              1 = release SCL (pulled high), 0 = drive low.
//  sda_oe     out  1              1 = drive SDA low, 0 = release; top level: SDA = sda_oe ? 0 : 'z.
//  sda_i      in   1              Sampled SDA pin; pre-synchronised by the top level.
// BEHAVIOUR
//  Reset (Reset==0 at posedge): state IDLE, scl_o=1, sda_oe=0, busy=0, done=0, nack=0, nack_idx=0,
//   tq counter and bit/byte counters 0. Reset mid-transaction aborts immediately; bus released next cycle.
//  Timebase: tq counter counts CLK_DIV-1 down to 0; phase/state advances only when it wraps.
//  IDLE: scl_o=1, sda_oe=0. If start=1: latch inputs, clear nack/nack_idx, go START next cycle.
//   start while busy is ignored, as is start on the done cycle; it is accepted from the next cycle (IDLE).
//  START (3 tq): tq0-1 SCL high, SDA low; tq2 SCL low, SDA low.
//  BIT (4 tq per bit, 8 bits, MSB first): tq0 SCL low, drive bit (sda_oe = ~bit);
//   tq1-2 SCL high; tq3 SCL low. SDA changes only in tq0.
//  ACK (4 tq): sda_oe=0 throughout; SCL as in BIT; sda_i is sampled on the final Clk of tq2.
//   sda_i=0: next byte, or STOP when bytes sent == 1+nbytes.
//   sda_i=1: nack<=1, nack_idx<=current byte index, go to STOP (remaining bytes skipped).
//  STOP (3 tq): tq0 SCL low, SDA low; tq1 SCL high, SDA low; tq2 SCL high, SDA released.
//   done=1 on the final Clk of tq2, with busy still 1; IDLE on the next cycle.
//  Latency from accept to done: CLK_DIV*(6 + 36*(1+nbytes_clamped)) cycles, +1 for the accept cycle.
//  nbytes=0: address only, which probes the device. Inputs changing while busy have no effect.
//  nack holds its value through IDLE until the next accepted start.
// TESTING (CLK_DIV=4, MAX_BYTES=2, slave model ACKs unless stated)
//  1 Reset low 3 cycles -> scl_o=1, sda_oe=0, busy=0, done=0, nack=0 throughout and after release.
//  2 start, dev_addr=7'h1A, nbytes=2, wr_data=16'h1E_00 -> bus decodes 0x34,0x1E,0x00 with ACKs;
//    done exactly 1+4*(6+108)=457 cycles after accept (accept cycle = 1); nack=0.
//  3 Same transaction; slave NACKs byte 1 -> 0x34 and 0x1E sent, STOP follows the ACK slot;
//    done with nack=1, nack_idx=1; 0x00 never driven.
//  4 nbytes=0, dev_addr=7'h1A, no slave (sda_i=1) -> only 0x34 sent; nack=1, nack_idx=0;
//    done 1+4*42=169 cycles after accept.
//  5 nbytes=3 (> MAX) -> exactly 2 data bytes sent. start pulsed mid-transfer -> ignored.
//    start held high across done -> second transaction begins the cycle after done.
//  6 Reset asserted during bit 4 of byte 1 -> next cycle scl_o=1, sda_oe=0, busy=0, no done;
//    a new start then completes normally. Monitor: SDA never changes while SCL is high, except in START and STOP.

Source files
------------

// File: rtl/i2c_write_master.sv
// I2C write-only master: START, {dev_addr,0}, up to MAX_BYTES data bytes with ACK checks, STOP.
// Accept->done takes CLK_DIV*(6+36*(1+nbytes)) cycles; no backpressure, start is ignored while busy.
module i2c_write_master #(
  parameter int CLK_DIV   = 4,
  parameter int MAX_BYTES = 2,
  parameter int NB_W      = $clog2(MAX_BYTES + 1)
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [6:0]             dev_addr,
  input  logic [NB_W-1:0]        nbytes,
  input  logic [8*MAX_BYTES-1:0] wr_data,
  output logic                   busy,
  output logic                   done,
  output logic                   nack,
  output logic [NB_W-1:0]        nack_idx,
  output logic                   scl_o,
  output logic                   sda_oe,
  input  logic                   sda_i
);
  localparam int              TQ_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TQ_W-1:0] TQ_MAX = TQ_W'(CLK_DIV - 1);
  localparam logic [NB_W-1:0] NB_MAX = NB_W'(MAX_BYTES);

  typedef enum logic [2:0] {S_IDLE, S_START, S_BIT, S_ACK, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic [TQ_W-1:0]        tq_cnt;
  logic [1:0]             phase_q;
  logic [2:0]             bit_cnt;
  logic [NB_W-1:0]        byte_cnt;
  logic [NB_W-1:0]        last_idx;
  logic [7:0]             shreg;
  logic [8*MAX_BYTES-1:0] data_buf;
  logic                   tick;
  logic                   accept;

  assign tick   = (tq_cnt == '0);
  assign accept = (state_q == S_IDLE) && start;
  assign busy   = (state_q != S_IDLE);

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      tq_cnt  <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        tq_cnt  <= TQ_MAX;
        phase_q <= '0;
      end else if (tick) begin
        tq_cnt  <= TQ_MAX;
        phase_q <= (state_d != state_q) ? 2'd0 : phase_q + 2'd1;
      end else begin
        tq_cnt <= tq_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    scl_o   = 1'b1;
    sda_oe  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_START;
      end
      S_START: begin
        scl_o  = (phase_q != 2'd2);
        sda_oe = 1'b1;
        if (tick && phase_q == 2'd2) state_d = S_BIT;
      end
      S_BIT: begin
        scl_o  = (phase_q == 2'd1) || (phase_q == 2'd2);
        sda_oe = ~shreg[7];
        if (tick && phase_q == 2'd3 && bit_cnt == 3'd7) state_d = S_ACK;
      end
      S_ACK: begin
        // nack was already set from the tq2 sample when the slave refused this byte
        scl_o = (phase_q == 2'd1) || (phase_q == 2'd2);
        if (tick && phase_q == 2'd3)
          state_d = (nack || byte_cnt == last_idx) ? S_STOP : S_BIT;
      end
      S_STOP: begin
        scl_o  = (phase_q != 2'd0);
        sda_oe = (phase_q != 2'd2);
        if (tick && phase_q == 2'd2) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      last_idx <= '0;
      shreg    <= '0;
      data_buf <= '0;
      nack     <= 1'b0;
      nack_idx <= '0;
    end else if (accept) begin
      bit_cnt  <= '0;
      byte_cnt <= '0;
      last_idx <= (nbytes > NB_MAX) ? NB_MAX : nbytes;
      shreg    <= {dev_addr, 1'b0};
      data_buf <= wr_data;
      nack     <= 1'b0;
      nack_idx <= '0;
    end else if (tick) begin
      if (state_q == S_BIT && phase_q == 2'd3) begin
        shreg   <= {shreg[6:0], 1'b0};
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state_q == S_ACK && phase_q == 2'd2 && sda_i) begin
        nack     <= 1'b1;
        nack_idx <= byte_cnt;
      end
      if (state_q == S_ACK && state_d == S_BIT) begin
        shreg    <= data_buf[8*MAX_BYTES-1 -: 8];
        data_buf <= data_buf << 8;
        byte_cnt <= byte_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: bus decoder + ACKing slave model feed byte/done scoreboards.
module tb_i2c_write_master;
  localparam int NB_W = 2;

  logic            Clk = 1'b0;
  logic            Reset = 1'b0;
  logic            start = 1'b0;
  logic [6:0]      dev_addr = '0;
  logic [NB_W-1:0] nbytes = '0;
  logic [15:0]     wr_data = '0;
  logic            busy, done, nack, scl_o, sda_oe, sda_i;
  logic [NB_W-1:0] nack_idx;
  logic            slave_drv = 1'b0;

  assign sda_i = !(sda_oe || slave_drv);

  i2c_write_master #(.CLK_DIV(4), .MAX_BYTES(2)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .dev_addr(dev_addr), .nbytes(nbytes),
    .wr_data(wr_data), .busy(busy), .done(done), .nack(nack), .nack_idx(nack_idx),
    .scl_o(scl_o), .sda_oe(sda_oe), .sda_i(sda_i)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { logic nk; logic [1:0] idx; int lat; } dexp_t;
  logic [7:0] exp_bytes[$];
  dexp_t      exp_done[$];
  dexp_t      de;

  int slave_present = 1;
  int nack_at = -1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic exp_txn(input logic nk, input logic [1:0] idx, input int lat);
    dexp_t e;
    e.nk = nk; e.idx = idx; e.lat = lat;
    exp_done.push_back(e);
  endtask

  // Done monitor: latency counted with the accept cycle as cycle 1
  int acc_cyc = 0;
  always @(negedge Clk) begin
    if (Reset && !busy && start) acc_cyc = cyc;
    if (done === 1'b1) begin
      if (exp_done.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done: got done at cycle %0d, expected none", cyc);
      end else begin
        de = exp_done.pop_front();
        chk("done_nack", nack, de.nk);
        if (de.nk) chk("nack_idx", nack_idx, de.idx);
        chk("done_latency", cyc - acc_cyc + 1, de.lat);
      end
    end
  end

  // Bus decoder and slave: bits latched on SCL rise, committed on SCL fall
  logic       prev_scl = 1'b1, prev_sda = 1'b1, cs, sd, pbit;
  logic [7:0] rx;
  int bitcnt = 0, byte_idx = 0;
  bit in_frame = 0, pend = 0;
  always @(negedge Clk) begin
    cs = scl_o;
    sd = !(sda_oe || slave_drv);
    if (!Reset) begin
      in_frame = 0; bitcnt = 0; byte_idx = 0; pend = 0; slave_drv = 1'b0;
    end else if (prev_scl && cs && prev_sda !== sd) begin
      if (!sd) begin
        chk("start_outside_frame", in_frame, 0);
        in_frame = 1; bitcnt = 0; byte_idx = 0;
      end else begin
        chk("stop_on_byte_boundary", bitcnt, 0);
        in_frame = 0;
      end
      pend = 0;
    end else if (!prev_scl && cs) begin
      pend = 1; pbit = sd;
    end else if (prev_scl && !cs && pend) begin
      pend = 0;
      if (bitcnt < 8) begin
        rx = {rx[6:0], pbit};
        bitcnt++;
        if (bitcnt == 8) begin
          chk("byte_in_frame", in_frame, 1);
          if (exp_bytes.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_byte: got %0h, expected no byte", rx);
          end else begin
            chk("bus_byte", rx, exp_bytes.pop_front());
          end
          slave_drv = (slave_present != 0) && (nack_at != byte_idx);
        end
      end else begin
        bitcnt = 0; byte_idx++; slave_drv = 1'b0;
      end
    end
    prev_scl = cs;
    prev_sda = !(sda_oe || slave_drv);
  end

  task automatic idle_chk(input string tag);
    chk({tag, "_scl"}, scl_o, 1);
    chk({tag, "_sda_oe"}, sda_oe, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic issue(input logic [6:0] a, input logic [1:0] n, input logic [15:0] d);
    @(posedge Clk); #1;
    dev_addr = a; nbytes = n; wr_data = d; start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin @(negedge Clk); n++; end while (done !== 1'b1 && n < 2000);
    if (done !== 1'b1) begin
      checks++; errors++;
      $display("FAIL %s_timeout: no done after %0d cycles, expected done", tag, n);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

  initial begin
    // 1: reset
    repeat (3) begin
      @(negedge Clk);
      idle_chk("rst");
      chk("rst_nack", nack, 0);
    end
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (2) begin
      @(negedge Clk);
      idle_chk("post_rst");
      chk("post_rst_nack", nack, 0);
    end

    // 2: full write, all ACKed
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h1E); exp_bytes.push_back(8'h00);
    exp_txn(1'b0, 2'd0, 457);
    issue(7'h1A, 2'd2, 16'h1E00);
    wait_done("s2");

    // 3: slave NACKs data byte 1
    @(negedge Clk); nack_at = 1;
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h1E);
    exp_txn(1'b1, 2'd1, 313);
    issue(7'h1A, 2'd2, 16'h1E00);
    wait_done("s3");
    repeat (3) begin
      @(negedge Clk);
      chk("nack_hold", nack, 1);
    end

    // 4: address probe with no slave
    nack_at = -1; slave_present = 0;
    exp_bytes.push_back(8'h34);
    exp_txn(1'b1, 2'd0, 169);
    issue(7'h1A, 2'd0, 16'hFFFF);
    wait_done("s4");

    // 5: clamp nbytes, ignored mid-transfer start, start held across done
    @(negedge Clk); slave_present = 1;
    exp_bytes.push_back(8'hA0); exp_bytes.push_back(8'hA5); exp_bytes.push_back(8'h3C);
    exp_txn(1'b0, 2'd0, 457);
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h42);
    exp_txn(1'b0, 2'd0, 313);
    issue(7'h50, 2'd3, 16'hA53C);
    repeat (100) @(posedge Clk);
    #1 dev_addr = 7'h11; start = 1'b1;
    @(posedge Clk); #1 start = 1'b0;
    repeat (50) @(posedge Clk);
    #1 dev_addr = 7'h1A; nbytes = 2'd1; wr_data = 16'h4299; start = 1'b1;
    wait_done("s5a");
    @(negedge Clk); chk("b2b_idle_cycle", busy, 0);
    @(negedge Clk); chk("b2b_restart", busy, 1);
    @(posedge Clk); #1 start = 1'b0;
    wait_done("s5b");

    // 6: reset during bit 4 of byte 1, then a clean transaction
    exp_bytes.push_back(8'h34);
    issue(7'h1A, 2'd2, 16'h1E00);
    repeat (228) @(posedge Clk);
    #1 Reset = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    idle_chk("abort");
    chk("abort_nack", nack, 0);
    @(posedge Clk); #1 Reset = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      chk("abort_no_done", done, 0);
      chk("abort_idle", busy, 0);
    end
    exp_bytes.push_back(8'h34); exp_bytes.push_back(8'h1E); exp_bytes.push_back(8'h00);
    exp_txn(1'b0, 2'd0, 457);
    issue(7'h1A, 2'd2, 16'h1E00);
    wait_done("s6");

    repeat (5) @(negedge Clk);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("dones_left", exp_done.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
